md_sched: RTL
=============

MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 SHALL have ports: clk  input  1  clock; all state updates on posedge.
REQ-002 SHALL have ports: resetn  input  1  synchronous, active-low reset.
REQ-003 SHALL have ports: req_valid  input  1  EX stage presents a multiply/divide/HI-LO-write operation.
REQ-004 SHALL have ports: req_ready  output  1  request accepted this cycle when req_valid && req_ready.
REQ-005 SHALL have ports: req_op  input  3  operation code: NONE=0, MUL=1, DIV=2, MTHI=3, MTLO=4.
REQ-006 SHALL have ports: req_sign  input  1  1 = signed (mult/div), 0 = unsigned (multu/divu).
REQ-007 SHALL have ports: src_a, src_b  input  32 each  rs and rt operand values.
REQ-008 SHALL have ports: flush  input  1  exception/ERET flush; aborts the in-flight operation.
REQ-009 SHALL have ports: rd_req  input  1  an MFHI/MFLO is in EX and needs HI/LO.
REQ-010 SHALL have ports: rd_stall  output  1  the EX stage must hold the MFHI/MFLO.
REQ-011 SHALL have ports: hi_o, lo_o  output  32 each  architectural HI/LO values.
REQ-012 SHALL have ports: busy  output  1  an operation is in flight (state is not IDLE).

Function
REQ-013 SHALL implement the FSM states IDLE, MUL, DIV and FIX.
REQ-014 SHALL set req_ready = 1 only in IDLE; a request accepted while flush=1 SHALL be dropped.
REQ-015 SHALL write src_a to HI (MTHI) or to LO (MTLO) on the acceptance edge and stay in IDLE.
REQ-016 SHALL handle MUL as IDLE->MUL, then 2 cycles in MUL; at the second MUL edge {HI,LO} = 64-bit product (signed or unsigned per req_sign) and the FSM returns to IDLE.
REQ-017 SHALL handle DIV as IDLE->DIV, 32 restoring-division iterations on operand magnitudes, one per cycle, then FIX for 1 cycle; at the FIX edge LO = quotient and HI = remainder, and the FSM returns to IDLE.
REQ-018 SHALL give signed DIV a quotient negative iff the operand signs differ, and a remainder with the sign of src_a; 0x80000000 / -1 SHALL give LO=0x80000000, HI=0.
REQ-019 SHALL, for divide by zero of either signedness, give LO=0xFFFFFFFF and HI=src_a after the full 33-cycle latency.
REQ-020 SHALL latch operands and req_sign at acceptance; input changes during busy SHALL have no effect.
REQ-021 SHALL set rd_stall = rd_req && busy, except as stated in REQ-026.
REQ-022 SHALL, when flush=1 in any state, force IDLE on the next edge and leave HI/LO unchanged; flush takes priority over a completing write in the same cycle.

Reset
REQ-023 SHALL, with resetn=0 at a posedge, set state IDLE, HI=0, LO=0 and clear all iteration counters and operand latches.
REQ-024 SHALL, while in reset, output req_ready=0, busy=0 and rd_stall=0; reset mid-operation SHALL discard the operation.

Configuration
REQ-025 SHALL compile the same-cycle result-forwarding path in or out with the macro MD_FWD_EN.
REQ-026 SHALL, with MD_FWD_EN defined, in the completing cycle (second MUL cycle, or FIX) drive rd_stall=0 and drive hi_o/lo_o combinationally with the new result.
REQ-027 SHALL, without MD_FWD_EN, keep rd_stall=1 through the completing cycle and drive hi_o/lo_o only from the registers.

Structure
REQ-028 SHALL define the req_op encodings and the DIV iteration count (32) in the shared header common.vh, alongside the existing ctrl bit indices.
REQ-029 SHALL place the iterative divider datapath in one sub-module, md_div_iter, holding shift registers and a counter; md_sched keeps the FSM, multiplier, HI/LO and the stall logic.

Verification
REQ-030 SHALL verify MUL signed: src_a=0xFFFFFFFE, src_b=3 -> after 2 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA; the unsigned case gives HI=2, LO=0xFFFFFFFA.
REQ-031 SHALL verify DIV signed: -7 / 2 -> after 33 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 -> LO=14, HI=2.
REQ-032 SHALL verify divide by zero: divu 5/0 -> LO=0xFFFFFFFF, HI=5, latency 33 cycles.
REQ-033 SHALL verify flush at DIV cycle 10 -> IDLE next cycle, HI/LO keep the prior MTHI/MTLO values 0x1234/0x5678, and req_ready=1.
REQ-034 SHALL verify rd_req held during MUL -> rd_stall=1 each cycle; in the completing cycle rd_stall=0 with the forwarded value (MD_FWD_EN) or 1 (without), then 0.
REQ-035 SHALL verify resetn=0 pulsed during MUL -> HI=LO=0, busy=0, and a following MTLO 7 yields LO=7.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
package md_sched_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_ITERS + 1);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MUL  = 3'd1,
        OP_DIV  = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    typedef struct packed {
        logic            sign;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } md_opnd_t;

    // Magnitude of a value that is two's complement only when sgn is set.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? XLEN'(-v) : v;
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step, DIV_ITERS steps.
module md_div_iter
    import md_sched_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            last_c
);

    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dsr_q;
    logic [XLEN-1:0]  rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    // Trial subtraction; diff[XLEN] set means the divisor did not fit.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dsr_q};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            quo_q <= '0;
            dsr_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            dsr_q <= divisor;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (step) begin
            if (diff[XLEN]) begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign last_c = step && (cnt_q == CNT_W'(DIV_ITERS - 1));
    assign quot   = quo_q;
    assign rem    = rem_q;

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply/divide scheduler with EX-stage handshake and MFHI/MFLO stall.
// Define MD_FWD_EN to forward the completing result to hi_o/lo_o without a stall.
module md_sched
    import md_sched_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_sign,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    input  logic            rd_req,
    output logic            rd_stall,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy
);

    md_state_e       state_q;
    logic            mul_cnt_q;
    md_opnd_t        opnd_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    logic              div_load;
    logic              div_step;
    logic              div_last_c;
    logic [XLEN-1:0]   div_quot;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] prod;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   res_hi;
    logic [XLEN-1:0]   res_lo;

    assign div_load = resetn && !flush && req_valid && (state_q == ST_IDLE)
                      && (req_op == OP_DIV);
    assign div_step = (state_q == ST_DIV) && !flush;

    md_div_iter u_div (
        .clk      (clk),
        .resetn   (resetn),
        .load     (div_load),
        .step     (div_step),
        .dividend (mag(src_a, req_sign)),
        .divisor  (mag(src_b, req_sign)),
        .quot     (div_quot),
        .rem      (div_rem),
        .last_c   (div_last_c)
    );

    // Result of the completing cycle: low 64 bits of the extended product, or the fixed-up quotient.
    always_comb begin
        mul_a  = opnd_q.sign ? {{XLEN{opnd_q.a[XLEN-1]}}, opnd_q.a} : {{XLEN{1'b0}}, opnd_q.a};
        mul_b  = opnd_q.sign ? {{XLEN{opnd_q.b[XLEN-1]}}, opnd_q.b} : {{XLEN{1'b0}}, opnd_q.b};
        prod   = mul_a * mul_b;
        neg_q  = opnd_q.sign && (opnd_q.a[XLEN-1] ^ opnd_q.b[XLEN-1]);
        neg_r  = opnd_q.sign && opnd_q.a[XLEN-1];
        res_hi = prod[2*XLEN-1:XLEN];
        res_lo = prod[XLEN-1:0];
        if (state_q == ST_FIX) begin
            if (opnd_q.b == '0) begin
                res_lo = '1;
                res_hi = opnd_q.a;
            end else begin
                res_lo = neg_q ? XLEN'(-div_quot) : div_quot;
                res_hi = neg_r ? XLEN'(-div_rem)  : div_rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            mul_cnt_q <= 1'b0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (flush) begin
            state_q   <= ST_IDLE;
            mul_cnt_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        case (req_op)
                            OP_MUL: begin
                                opnd_q    <= '{sign: req_sign, a: src_a, b: src_b};
                                mul_cnt_q <= 1'b0;
                                state_q   <= ST_MUL;
                            end
                            OP_DIV: begin
                                opnd_q  <= '{sign: req_sign, a: src_a, b: src_b};
                                state_q <= ST_DIV;
                            end
                            OP_MTHI: hi_q <= src_a;
                            OP_MTLO: lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (mul_cnt_q) begin
                        hi_q      <= res_hi;
                        lo_q      <= res_lo;
                        mul_cnt_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        mul_cnt_q <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_last_c) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = resetn && (state_q == ST_IDLE);
    assign busy      = resetn && (state_q != ST_IDLE);

`ifdef MD_FWD_EN
    logic wr_c;
    // A completing write that is not flushed is visible to MFHI/MFLO in the same cycle.
    assign wr_c     = resetn && !flush
                      && (((state_q == ST_MUL) && mul_cnt_q) || (state_q == ST_FIX));
    assign rd_stall = rd_req && busy && !wr_c;
    assign hi_o     = wr_c ? res_hi : hi_q;
    assign lo_o     = wr_c ? res_lo : lo_q;
`else
    assign rd_stall = rd_req && busy;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;
`endif

endmodule
